// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitch-free two-source clock mux: arbitrates two requesters,
// drives the mux select and waits for the mux to report the new path before a dwell.
// Optional switch timeout enabled by defining CLK_SW_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request; only state with busy=0
// GRANT    | grant pulse visible; sel already driven to the winner's target
// WAIT_ACK | waiting for new-path ack=1 and old-path ack=0
// DWELL    | holding after a completed switch before accepting new requests
// ERR      | switch timed out; sticky err until err_clr
module clk_switch_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int DWELL_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit SEL_RESET      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] tgt,
  input  logic       ack_0,
  input  logic       ack_1,
  input  logic       err_clr,
  output logic       sel,
  output logic [1:0] gnt,
  output logic       done,
  output logic       busy,
  output logic       err
);

  localparam int DW = $clog2(DWELL_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_ACK,
    S_DWELL,
    S_ERR
  } state_t;

  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_0, sync_1;
  logic a_0, a_1, ack_ok, win;
  logic sel_nx, done_nx, busy_nx, ptr, ptr_nx;
  logic [1:0] gnt_nx;
  logic [DW-1:0] dcnt, dcnt_nx;

  // ack_1 synchronizer resets high because the mux comes out of reset on path 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0 <= '0;
      sync_1 <= '1;
    end else begin
      sync_0[0] <= ack_0;
      sync_1[0] <= ack_1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_0[i] <= sync_0[i-1];
        sync_1[i] <= sync_1[i-1];
      end
    end
  end

  assign a_0    = sync_0[SYNC_STAGES-1];
  assign a_1    = sync_1[SYNC_STAGES-1];
  assign ack_ok = sel ? (a_1 & ~a_0) : (a_0 & ~a_1);
  assign win    = (req == 2'b11) ? ptr : req[1];

`ifdef CLK_SW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic err_q, err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= tcnt_nx;
      err_q <= err_nx;
    end
  end

  assign err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sel   <= SEL_RESET;
      gnt   <= 2'b00;
      done  <= 1'b0;
      busy  <= 1'b0;
      ptr   <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      done  <= done_nx;
      busy  <= busy_nx;
      ptr   <= ptr_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    gnt_nx   = 2'b00;
    done_nx  = 1'b0;
    ptr_nx   = ptr;
    dcnt_nx  = dcnt;
`ifdef CLK_SW_TIMEOUT_EN
    tcnt_nx  = tcnt;
    err_nx   = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nx = S_GRANT;
          gnt_nx   = win ? 2'b10 : 2'b01;
          ptr_nx   = ~win;
          if (tgt[win] == sel) done_nx = 1'b1;
          else                 sel_nx  = tgt[win];
        end
      end
      // done already high here means no switch was needed
      S_GRANT: begin
        if (done) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_WAIT_ACK;
`ifdef CLK_SW_TIMEOUT_EN
          tcnt_nx  = '0;
`endif
        end
      end
      S_WAIT_ACK: begin
        if (ack_ok) begin
          state_nx = S_DWELL;
          dcnt_nx  = '0;
          if (DWELL_CYCLES == 0) done_nx = 1'b1;
        end
`ifdef CLK_SW_TIMEOUT_EN
        else if (int'(tcnt) + 1 >= TIMEOUT_CYCLES) begin
          state_nx = S_ERR;
          err_nx   = 1'b1;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
`endif
      end
      S_DWELL: begin
        if (done) begin
          state_nx = S_IDLE;
        end else begin
          dcnt_nx = dcnt + 1'b1;
          if (dcnt_nx == DW'(DWELL_CYCLES)) done_nx = 1'b1;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_nx = S_IDLE;
`ifdef CLK_SW_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed scenarios with literal timing expectations plus
// randomized requests, all outputs checked each cycle against a transaction-level model.
module tb_clk_switch_ctrl;

  localparam int SYNC  = 2;
  localparam int DWELL = 16;
  localparam int TO    = 8;
  localparam bit SEL_R = 1'b1;
`ifdef CLK_SW_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst, ack_0, ack_1, err_clr;
  logic [1:0] req, tgt;
  logic sel, done, busy, err;
  logic [1:0] gnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  clk_switch_ctrl #(
    .SYNC_STAGES(SYNC), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TO), .SEL_RESET(SEL_R)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .tgt(tgt), .ack_0(ack_0), .ack_1(ack_1),
    .err_clr(err_clr), .sel(sel), .gnt(gnt), .done(done), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- mux stand-in: old path drops, then new path reports ----------------
  bit ack_manual = 0;
  bit ack_freeze = 0;
  logic mux_tgt = 1'b1;
  int mux_cnt = 0;

  always begin
    @(posedge clk);
    #3;
    if (!ack_manual && !ack_freeze) begin
      if (sel !== mux_tgt) begin
        mux_tgt = sel;
        mux_cnt = $urandom_range(2, 6);
      end else if (mux_cnt > 0) begin
        mux_cnt--;
        if (mux_cnt == 1) begin
          ack_0 = 1'b0;
          ack_1 = 1'b0;
        end else if (mux_cnt == 0) begin
          if (mux_tgt) ack_1 = 1'b1;
          else         ack_0 = 1'b0 | 1'b1;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum {P_IDLE, P_GRANTED, P_WAIT, P_HOLD, P_FAULT} phase_t;
  phase_t phase = P_IDLE;
  bit h0[SYNC];
  bit h1[SYNC];
  logic m_sel = SEL_R, m_done = 0, m_busy = 0, m_err = 0;
  logic [1:0] m_gnt = 0;
  int ptr = 0, remaining = 0, wait_cycles = 0;
  bit switching = 0;

  always @(posedge clk) begin
    bit a0, a1, was_done;
    int w;
    a0 = h0[SYNC-1];
    a1 = h1[SYNC-1];
    was_done = m_done;
    if (rst) begin
      phase = P_IDLE; m_sel = SEL_R; m_gnt = 0; m_done = 0; m_err = 0; ptr = 0;
      for (int i = 0; i < SYNC; i++) begin h0[i] = 0; h1[i] = 1; end
    end else begin
      for (int i = SYNC - 1; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; end
      h0[0] = ack_0;
      h1[0] = ack_1;
      m_gnt = 0;
      m_done = 0;
      case (phase)
        P_IDLE: if (req != 0) begin
          w = (req == 2'b11) ? ptr : ((req == 2'b10) ? 1 : 0);
          ptr = 1 - w;
          m_gnt = 2'(1 << w);
          phase = P_GRANTED;
          if (tgt[w] == m_sel) begin m_done = 1; switching = 0; end
          else begin m_sel = tgt[w]; switching = 1; end
        end
        P_GRANTED: begin
          phase = switching ? P_WAIT : P_IDLE;
          wait_cycles = 0;
        end
        P_WAIT: begin
          if ((m_sel && a1 && !a0) || (!m_sel && a0 && !a1)) begin
            phase = P_HOLD;
            remaining = DWELL;
            if (remaining == 0) m_done = 1;
          end else if (TO_EN) begin
            wait_cycles++;
            if (wait_cycles >= TO) begin phase = P_FAULT; m_err = 1; end
          end
        end
        P_HOLD: begin
          if (was_done) phase = P_IDLE;
          else begin
            remaining--;
            if (remaining == 0) m_done = 1;
          end
        end
        P_FAULT: if (err_clr) begin phase = P_IDLE; m_err = 0; end
        default: phase = P_IDLE;
      endcase
    end
    m_busy = (phase != P_IDLE);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel",  sel,  m_sel);
      chk("gnt",  gnt,  m_gnt);
      chk("done", done, m_done);
      chk("busy", busy, m_busy);
      chk("err",  err,  m_err);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, ng, nd;
    logic [1:0] gl[3];
    logic sl[3];
    rst = 1; req = 0; tgt = 0; err_clr = 0; ack_0 = 0; ack_1 = 1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_sel", sel, 1); chk("rst_busy", busy, 0); chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
    rst = 0;
    @(negedge clk);

    // no-change request completes with the grant
    req = 2'b01; tgt = 2'b01;
    @(negedge clk);
    chk("nochg_gnt", gnt, 2'b01); chk("nochg_done", done, 1); chk("nochg_sel", sel, 1);
    req = 0;
    @(negedge clk);
    chk("nochg_idle", busy, 0);

    // switch to path 0 with hand-driven acks including glitches
    ack_manual = 1;
    req = 2'b01; tgt = 2'b00;
    @(negedge clk);
    chk("sw_gnt", gnt, 2'b01); chk("sw_sel", sel, 0); chk("sw_done", done, 0);
    req = 0; k = 0;
    @(negedge clk); k++;
    #1 ack_0 = 1; #2 ack_0 = 0;
    @(negedge clk); k++;
    #1 ack_0 = 1; #6 ack_0 = 0;
    @(negedge clk); k++;
    ack_1 = 0; ack_0 = 1;
    while (done !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    chk("sw_done_latency", k, 22);
    mux_tgt = 1'b0; mux_cnt = 0; ack_manual = 0;
    @(negedge clk);
    chk("sw_idle", busy, 0);

    // both requesters held: round-robin alternation
    rst = 1; @(negedge clk); rst = 0;
    req = 2'b11; tgt = 2'b01; ng = 0; k = 0;
    while (ng < 3 && k < 300) begin
      @(negedge clk); k++;
      if (gnt != 0) begin gl[ng] = gnt; sl[ng] = sel; ng++; end
    end
    req = 0;
    chk("rr_count", ng, 3);
    chk("rr_g0", gl[0], 2'b01); chk("rr_g1", gl[1], 2'b10); chk("rr_g2", gl[2], 2'b01);
    chk("rr_s0", sl[0], 1); chk("rr_s1", sl[1], 0); chk("rr_s2", sl[2], 1);
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);

    // reset during dwell drops the request
    req = 2'b01; tgt = 2'b00;
    @(negedge clk);
    chk("rd_gnt", gnt, 2'b01);
    req = 0; nd = 0;
    repeat (14) begin @(negedge clk); nd += int'(done); end
    rst = 1; @(negedge clk); rst = 0;
    chk("rd_sel", sel, 1); chk("rd_busy", busy, 0);
    repeat (25) begin @(negedge clk); nd += int'(done); end
    chk("rd_no_done", nd, 0);
    req = 2'b01; tgt = 2'b00; k = 0;
    while (done !== 1'b1 && k < 80) begin
      @(negedge clk); k++;
      if (gnt[0]) req = 0;
    end
    chk("rd_reissue_done", done, 1);
    repeat (10) @(negedge clk);

`ifdef CLK_SW_TIMEOUT_EN
    ack_freeze = 1;
    req = 2'b01; tgt = {1'b0, ~sel};
    @(negedge clk);
    chk("to_gnt", gnt, 2'b01);
    req = 0; k = 0; nd = 0;
    while (err !== 1'b1 && k < 40) begin @(negedge clk); k++; nd += int'(done); end
    chk("to_err_latency", k, 9); chk("to_busy", busy, 1); chk("to_no_done", nd, 0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", err, 1);
    err_clr = 1; @(negedge clk); err_clr = 0;
    chk("to_clr_err", err, 0); chk("to_clr_busy", busy, 0);
    ack_freeze = 0;
    repeat (12) @(negedge clk);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) begin
          tgt[i] = 1'($urandom_range(0, 1));
          req[i] = 1'b1;
        end
      end
      if (TO_EN) begin
        err_clr = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 199) == 0) ack_freeze = ~ack_freeze;
      end
    end
    rst = 0; req = 0; err_clr = 0; ack_freeze = 0;
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flop stages on each ack input.
REQ-002 Parameter DWELL_CYCLES, default 16, minimum clk cycles held after a completed switch before the next request is accepted.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max WAIT_ACK cycles (used only with CLK_SW_TIMEOUT_EN).
REQ-004 Parameter SEL_RESET, default 1, sel value after reset (matches mux reset state: clk_in_1 enabled).
REQ-005 clk  input  1  always-on controller clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  2  per-requester switch request, level, held until gnt.
REQ-008 tgt  input  2  tgt[i] = clock source requested by requester i, stable while req[i]=1.
REQ-009 ack_0 / ack_1  input  1 each  mux path-enable status (sel_sample of each path), asynchronous to clk.
REQ-010 sel  output  1  select to glitch-free mux.
REQ-011 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-012 done  output  1  one-cycle pulse: granted request completed.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky switch-timeout flag.
REQ-015 err_clr  input  1  clears err and leaves ERR.

Function
REQ-016 ack_0/ack_1 SHALL pass through SYNC_STAGES-flop synchronizers (reset 0 and 1 respectively) before use; a_0/a_1 denote synchronized values.
REQ-017 FSM states: IDLE, GRANT, WAIT_ACK, DWELL, ERR; all outputs registered.
REQ-018 IDLE: any req[i]=1 -> GRANT next cycle; requests ignored in all other states.
REQ-019 Arbitration: both req high -> requester at round-robin pointer wins; pointer moves to the other requester after each grant; pointer resets to 0.
REQ-020 GRANT: gnt[winner]=1 for exactly one cycle; if tgt[winner]==sel then done=1 same cycle, next IDLE; else sel<=tgt[winner] same cycle, next WAIT_ACK.
REQ-021 WAIT_ACK exits to DWELL when new-path ack=1 AND old-path ack=0 (sel=1: a_1=1,a_0=0; sel=0: a_0=1,a_1=0).
REQ-022 DWELL: 1-bit-wider counter loaded 0 on entry; after DWELL_CYCLES cycles done=1 one cycle, next IDLE; DWELL_CYCLES=0 -> done on first DWELL cycle.
REQ-023 sel SHALL change only in GRANT; never while busy otherwise.
REQ-024 Latency: req seen in IDLE cycle N -> gnt cycle N+1; no-change request -> done cycle N+1.
REQ-025 busy=0 only in IDLE; gnt and done never asserted in IDLE.

Reset
REQ-026 rst=1 at any clock edge: state IDLE, sel=SEL_RESET, gnt=0, done=0, busy=0, err=0, counters 0, pointer 0, synchronizers to their reset values.
REQ-027 rst mid-operation SHALL drop the in-flight request with no done pulse; requester must re-request.

Configuration
REQ-028 Macro CLK_SW_TIMEOUT_EN defined: WAIT_ACK counts cycles; after TIMEOUT_CYCLES without exit condition -> ERR, err=1, sel held; ERR exits to IDLE when err_clr=1 (err cleared same edge); no done for the failed request.
REQ-029 Macro undefined: WAIT_ACK waits indefinitely, no timeout counter, ERR unreachable, err tied 0, err_clr ignored.

Verification
REQ-030 Reset, req=01, tgt[0]=1 -> gnt=01 next cycle, done same cycle, sel stays 1, no WAIT_ACK.
REQ-031 req=01, tgt[0]=0; model mux acks 4 cycles later -> sel=0 with gnt; WAIT_ACK until a_0=1,a_1=0; done exactly DWELL_CYCLES=16 cycles after DWELL entry.
REQ-032 req=11 continuously, tgt=01 -> grants alternate 01,10,01; sel toggles each switch; no new gnt while busy.
REQ-033 CLK_SW_TIMEOUT_EN, TIMEOUT_CYCLES=8, acks frozen -> err=1 after 8 WAIT_ACK cycles, busy=1, no done; err_clr=1 -> IDLE, err=0.
REQ-034 rst pulsed during DWELL -> sel=SEL_RESET, busy=0, no done; subsequent request serviced normally.
REQ-035 ack_0 toggled asynchronously to clk -> no exit from WAIT_ACK before SYNC_STAGES+1 cycles after stable ack.
